// File: rtl/pow2_burst_dec_if.sv
// Handshake bundle for pow2_burst_dec: request side (degree/len),
// one-hot beat output side, and the busy status flag.
// The optional out_therm signal exists only when POW2_THERM_EN is defined.
interface pow2_burst_dec_if #(
  parameter int DEG_W = 3
);
  localparam int OUT_W = 1 << DEG_W;

  logic             in_valid;
  logic             in_ready;
  logic [DEG_W-1:0] in_degree;
  logic [DEG_W-1:0] in_len;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
  logic             busy;
`ifdef POW2_THERM_EN
  logic [OUT_W-1:0] out_therm;
`endif

`ifdef POW2_THERM_EN
  // Producer of requests / consumer of beats (the environment)
  modport master (
    output in_valid, in_degree, in_len, out_ready,
    input  in_ready, out_valid, out_onehot, busy, out_therm
  );
  // Decoder side
  modport slave (
    input  in_valid, in_degree, in_len, out_ready,
    output in_ready, out_valid, out_onehot, busy, out_therm
  );
`else
  // Producer of requests / consumer of beats (the environment)
  modport master (
    output in_valid, in_degree, in_len, out_ready,
    input  in_ready, out_valid, out_onehot, busy
  );
  // Decoder side
  modport slave (
    input  in_valid, in_degree, in_len, out_ready,
    output in_ready, out_valid, out_onehot, busy
  );
`endif
endinterface

// File: rtl/pow2_burst_dec.sv
// pow2_burst_dec: streaming exponent-to-one-hot decoder.
// Accepts {degree, len} requests and emits len+1 one-hot beats, starting at
// 1 << degree and rotating left by one per beat (wrapping at the top bit).
// Beats are buffered in a 2-entry register FIFO so back-pressure never drops
// data; the FIFO head registers drive out_* directly (no in->out comb path).
// Optional feature macro: POW2_THERM_EN adds out_therm, the thermometer
// (all bits at and below the set bit) of the FIFO head.
module pow2_burst_dec #(
  parameter int DEG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  pow2_burst_dec_if.slave   bus
);
  localparam int OUT_W = 1 << DEG_W;

  typedef enum logic {IDLE, RUN} state_t;

  // Rotate a one-hot word left by one, top bit wrapping into bit 0.
  function automatic logic [OUT_W-1:0] rotl1(input logic [OUT_W-1:0] v);
    return {v[OUT_W-2:0], v[OUT_W-1]};
  endfunction

  // Decode a bit index to its one-hot word.
  function automatic logic [OUT_W-1:0] to_onehot(input logic [DEG_W-1:0] idx);
    logic [OUT_W-1:0] one;
    one = {{(OUT_W-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

`ifdef POW2_THERM_EN
  // Thermometer of a one-hot word; an all-zero input (empty FIFO) maps to 0
  // instead of the all-ones that (v << 1) - 1 would give.
  function automatic logic [OUT_W-1:0] to_therm(input logic [OUT_W-1:0] v);
    logic [OUT_W-1:0] one;
    one = {{(OUT_W-1){1'b0}}, 1'b1};
    if (v == '0) return '0;
    return (v << 1) - one;
  endfunction
`endif

  // Generator state
  state_t           state_q, state_d;
  logic [OUT_W-1:0] cur_q, cur_d;
  logic [DEG_W-1:0] left_q, left_d;

  // FIFO: head is the visible entry, tail the second; unused slots held at 0
  logic [OUT_W-1:0] head_q, head_d;
  logic [OUT_W-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             in_ready_c;

  assign fifo_full = (count_q == 2'd2);
  assign pop       = (count_q != 2'd0) && bus.out_ready;

  // FSM next-state: IDLE accepts a request, RUN pushes one beat per free slot
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    left_d     = left_q;
    push       = 1'b0;
    in_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          cur_d   = to_onehot(bus.in_degree);
          left_d  = bus.in_len;
          state_d = RUN;
        end
      end
      RUN: begin
        // A same-cycle pop frees the slot this push lands in
        if (!fifo_full || pop) begin
          push   = 1'b1;
          cur_d  = rotl1(cur_q);
          left_d = left_q - DEG_W'(1);
          if (left_q == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO next-state for every push/pop combination
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = cur_q;
        else                 tail_d = cur_q;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        tail_d  = '0;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new beat goes behind whatever remains
        if (count_q == 2'd1) begin
          head_d = cur_q;
        end else begin
          head_d = tail_q;
          tail_d = cur_q;
        end
      end
      default: ;
    endcase
  end

  // Control and FIFO registers; FIFO data is cleared so out_onehot reads 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Burst datapath registers; only meaningful in RUN, so no reset needed
  always_ff @(posedge clk) begin
    cur_q  <= cur_d;
    left_q <= left_d;
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = (count_q != 2'd0);
  assign bus.out_onehot = head_q;
  assign bus.busy       = (state_q == RUN) || (count_q != 2'd0);

`ifdef POW2_THERM_EN
  assign bus.out_therm  = to_therm(head_q);
`endif

endmodule

// File: tb/tb_pow2_burst_dec.sv
// Self-checking bench for pow2_burst_dec: directed scenarios plus randomized
// requests with random back-pressure, checked by a scoreboard queue of
// expected bit indices and a free-running monitor.
module tb_pow2_burst_dec;
  localparam int DEG_W = 3;
  localparam int OUT_W = 1 << DEG_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pow2_burst_dec_if #(.DEG_W(DEG_W)) ifc ();

  pow2_burst_dec #(.DEG_W(DEG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int tests = 0;
  int fails = 0;
  int beats_seen = 0;
  int exp_q[$];      // expected bit index of each upcoming beat
  bit rand_rdy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: beat k of a request starts at bit degree and walks up mod OUT_W
  task automatic model_push(input int deg, input int len);
    for (int k = 0; k <= len; k++) exp_q.push_back((deg + k) % OUT_W);
  endtask

  // Monitor: every beat consumed is compared against the scoreboard head
  initial begin
    int idx;
    logic [31:0] exp_oh;
    forever begin
      @(negedge clk);
      if (!rst && ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", ifc.out_onehot);
        end else begin
          idx = exp_q.pop_front();
          exp_oh = 32'(1) << idx;
          check("beat_onehot", 32'(ifc.out_onehot), exp_oh);
          check("beat_popcount", 32'($countones(ifc.out_onehot)), 32'd1);
`ifdef POW2_THERM_EN
          check("beat_therm", 32'(ifc.out_therm), ((32'(1) << (idx + 1)) - 1) & 32'hFF);
`endif
          beats_seen++;
        end
      end
    end
  end

  // Random back-pressure, changed just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) ifc.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Issue one request; returns 1 time unit after the accepting edge
  task automatic send(input int deg, input int len);
    int n = 0;
    ifc.in_valid  = 1'b1;
    ifc.in_degree = DEG_W'(deg);
    ifc.in_len    = DEG_W'(len);
    @(negedge clk);
    while (!ifc.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 100 cycles");
    end else begin
      model_push(deg, len);
    end
    @(posedge clk);
    #1;
    ifc.in_valid  = 1'b0;
    ifc.in_degree = DEG_W'($urandom_range(0, OUT_W - 1));
    ifc.in_len    = DEG_W'($urandom_range(0, OUT_W - 1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || ifc.busy) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_not_busy", 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_degree = '0;
    ifc.in_len    = '0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset / idle state
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_out_onehot", 32'(ifc.out_onehot), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
`ifdef POW2_THERM_EN
    check("rst_out_therm", 32'(ifc.out_therm), 32'd0);
`endif

    // Single beat: degree 3, len 0
    send(3, 0);
    check("single_in_ready_low", 32'(ifc.in_ready), 32'd0);
    check("single_not_yet_valid", 32'(ifc.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("single_valid", 32'(ifc.out_valid), 32'd1);
    check("single_onehot", 32'(ifc.out_onehot), 32'h08);
    check("single_in_ready_back", 32'(ifc.in_ready), 32'd1);
    wait_drain();

    // Wrap: degree 6, len 3 on consecutive cycles
    send(6, 3);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("wrap_consecutive_valid", 32'(ifc.out_valid), 32'd1);
    end
    wait_drain();

    // Back-pressure: degree 0, len 7 with out_ready low for 5 cycles
    ifc.out_ready = 1'b0;
    send(0, 7);
    repeat (5) @(posedge clk);
    #1;
    check("bp_valid", 32'(ifc.out_valid), 32'd1);
    check("bp_head", 32'(ifc.out_onehot), 32'h01);
    check("bp_busy", 32'(ifc.busy), 32'd1);
    check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
    check("bp_nothing_consumed", 32'(exp_q.size()), 32'd8);
    ifc.out_ready = 1'b1;
    wait_drain();

    // Reset mid-burst: degree 2, len 5, reset after two beats
    begin
      int base;
      int n = 0;
      base = beats_seen;
      send(2, 5);
      while (beats_seen < base + 2 && n < 50) begin
        @(posedge clk);
        n++;
      end
      check("midrst_two_beats", 32'(beats_seen - base), 32'd2);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      check("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
      check("midrst_busy", 32'(ifc.busy), 32'd0);
      check("midrst_in_ready", 32'(ifc.in_ready), 32'd1);
      check("midrst_onehot", 32'(ifc.out_onehot), 32'd0);
      base = beats_seen;
      send(1, 0);
      wait_drain();
      repeat (3) @(posedge clk);
      #1;
      check("midrst_one_beat_only", 32'(beats_seen - base), 32'd1);
    end

`ifdef POW2_THERM_EN
    // Thermometer: degree 4, len 1
    send(4, 1);
    @(posedge clk);
    #1;
    check("therm_first", 32'(ifc.out_therm), 32'h1F);
    check("therm_first_onehot", 32'(ifc.out_onehot), 32'h10);
    @(posedge clk);
    #1;
    check("therm_second", 32'(ifc.out_therm), 32'h3F);
    check("therm_second_onehot", 32'(ifc.out_onehot), 32'h20);
    wait_drain();
`endif

    // Randomized requests under random back-pressure
    rand_rdy = 1;
    for (int r = 0; r < 60; r++) begin
      send($urandom_range(0, OUT_W - 1), $urandom_range(0, OUT_W - 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #0;
    end
    rand_rdy = 0;
    @(posedge clk);
    #2;
    ifc.out_ready = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard against a hung DUT
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
